// File: rtl/mul_div_unit.sv
// mul_div_unit: EX-stage multiply/divide unit that owns the HI/LO registers.
//   MULT/MULTU finish in one cycle. DIV/DIVU use a 32-step restoring divider.
//   MFHI/MFLO/MTHI/MTLO are also handled here.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   reg_stall_i              EX instruction is not retiring this cycle
//   alu_stall_o              divider busy, freeze the pipeline
//   oper_i, func_i           operation class and MIPS funct code
//   source_a_i, source_b_i   rs / rt operands
//   result_o                 GPR result (MFHI/MFLO, otherwise 0)
//   hi_o, lo_o               architectural HI/LO
//   hi_write_i/_data_i,
//   lo_write_i/_data_i       late-stage HI/LO writes
module mul_div_unit #(
    parameter int                 DATA_W    = 32,
    parameter int                 OPER_W    = 4,
    parameter int                 FUNC_W    = 6,
    parameter logic [OPER_W-1:0]  OPER_ALUS = OPER_W'(2)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              reg_stall_i,
    output logic              alu_stall_o,
    input  logic [OPER_W-1:0] oper_i,
    input  logic [FUNC_W-1:0] func_i,
    input  logic [DATA_W-1:0] source_a_i,
    input  logic [DATA_W-1:0] source_b_i,
    output logic [DATA_W-1:0] result_o,
    output logic [DATA_W-1:0] hi_o,
    input  logic              hi_write_i,
    input  logic [DATA_W-1:0] hi_write_data_i,
    output logic [DATA_W-1:0] lo_o,
    input  logic              lo_write_i,
    input  logic [DATA_W-1:0] lo_write_data_i
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              st_q;
    logic [CW-1:0]       cnt_q;
    logic [DATA_W-1:0]   hi_q, lo_q, hi_d, lo_d;
    logic [DATA_W-1:0]   quo_q, rem_q, dvs_q;
    logic                qneg_q, rneg_q, dz_q;

    logic                sel, is_mfhi, is_mthi, is_mflo, is_mtlo, is_mult, is_multu, is_div, is_divu;
    logic                is_mul, start, ex_go, commit, take;
    logic [2*DATA_W-1:0] ax, bx, prod;
    logic [DATA_W-1:0]   a_mag, b_mag, rem_nx, quo_res, rem_res;
    logic [DATA_W:0]     sh;

    assign sel      = oper_i == OPER_ALUS;
    assign is_mfhi  = sel && func_i == FUNC_W'('h10);
    assign is_mthi  = sel && func_i == FUNC_W'('h11);
    assign is_mflo  = sel && func_i == FUNC_W'('h12);
    assign is_mtlo  = sel && func_i == FUNC_W'('h13);
    assign is_mult  = sel && func_i == FUNC_W'('h18);
    assign is_multu = sel && func_i == FUNC_W'('h19);
    assign is_div   = sel && func_i == FUNC_W'('h1A);
    assign is_divu  = sel && func_i == FUNC_W'('h1B);

    assign is_mul = is_mult | is_multu;
    assign ex_go  = ~reg_stall_i;
    assign start  = st_q == IDLE && (is_div | is_divu);
    assign commit = st_q == DONE && ex_go;

    // Sign-extending only for MULT lets one 2W-bit modular multiply serve both forms.
    assign ax   = {{DATA_W{is_mult & source_a_i[DATA_W-1]}}, source_a_i};
    assign bx   = {{DATA_W{is_mult & source_b_i[DATA_W-1]}}, source_b_i};
    assign prod = ax * bx;

    assign a_mag = (is_div & source_a_i[DATA_W-1]) ? -source_a_i : source_a_i;
    assign b_mag = (is_div & source_b_i[DATA_W-1]) ? -source_b_i : source_b_i;

    // Restoring step: the partial remainder stays below the divisor, so W+1 bits suffice.
    assign sh     = {rem_q, quo_q[DATA_W-1]};
    assign take   = sh >= {1'b0, dvs_q};
    assign rem_nx = take ? DATA_W'(sh - {1'b0, dvs_q}) : sh[DATA_W-1:0];

    assign quo_res = dz_q ? '1 : (qneg_q ? -quo_q : quo_q);
    assign rem_res = rneg_q ? -rem_q : rem_q;

    // EX-stage writes belong to the younger instruction and override late-stage writes.
    always_comb begin
        hi_d = commit ? rem_res :
               (ex_go & is_mul) ? prod[2*DATA_W-1:DATA_W] :
               (ex_go & is_mthi) ? source_a_i :
               hi_write_i ? hi_write_data_i : hi_q;
        lo_d = commit ? quo_res :
               (ex_go & is_mul) ? prod[DATA_W-1:0] :
               (ex_go & is_mtlo) ? source_a_i :
               lo_write_i ? lo_write_data_i : lo_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            case (st_q)
                IDLE: if (start) begin
                    st_q   <= BUSY;
                    cnt_q  <= '0;
                    quo_q  <= a_mag;
                    rem_q  <= '0;
                    dvs_q  <= b_mag;
                    qneg_q <= is_div & (source_a_i[DATA_W-1] ^ source_b_i[DATA_W-1]);
                    rneg_q <= is_div & source_a_i[DATA_W-1];
                    dz_q   <= source_b_i == '0;
                end
                BUSY: begin
                    rem_q <= rem_nx;
                    quo_q <= {quo_q[DATA_W-2:0], take};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DATA_W - 1)) st_q <= DONE;
                end
                DONE: if (ex_go) st_q <= IDLE;
                default: st_q <= IDLE;
            endcase
        end
    end

    // The issue cycle stalls combinationally so the DIV stays in EX while operands latch.
    assign alu_stall_o = rst_ni & (start | st_q == BUSY);
    assign result_o    = is_mfhi ? hi_q : is_mflo ? lo_q : '0;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized and directed checks of mul_div_unit against a plain arithmetic model.
module tb_mul_div_unit;
    localparam logic [3:0] ALUS = 4'd2;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

    logic        clk = 0, rst_n = 1, reg_stall = 0, hi_write = 0, lo_write = 0;
    logic [3:0]  oper = '0;
    logic [5:0]  func = '0;
    logic [31:0] sa = '0, sb = '0, hwd = '0, lwd = '0;
    logic        alu_stall;
    logic [31:0] result, hi, lo;
    int          checks = 0, errors = 0;

    mul_div_unit #(.DATA_W(32), .OPER_W(4), .FUNC_W(6), .OPER_ALUS(ALUS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .reg_stall_i(reg_stall), .alu_stall_o(alu_stall),
        .oper_i(oper), .func_i(func), .source_a_i(sa), .source_b_i(sb), .result_o(result),
        .hi_o(hi), .hi_write_i(hi_write), .hi_write_data_i(hwd),
        .lo_o(lo), .lo_write_i(lo_write), .lo_write_data_i(lwd)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        oper = ALUS; func = f; sa = a; sb = b;
    endtask

    task automatic idle();
        oper = '0; func = '0;
    endtask

    function automatic logic [63:0] mul_model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint la, lb;
        la = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        lb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        return 64'(la * lb);
    endfunction

    function automatic void div_model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [31:0] r);
        longint la, lb;
        if (b == 0) begin
            q = '1; r = a;
            return;
        end
        la = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        lb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        q = 32'(la / lb);
        r = 32'(la % lb);
    endfunction

    task automatic run_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input string nm);
        @(negedge clk);
        drive(sgn ? F_MULT : F_MULTU, a, b); reg_stall = 0; #1;
        checks++;
        if (alu_stall !== 1'b0) begin errors++; $display("FAIL %s stall: got %b exp 0", nm, alu_stall); end
        checks++;
        if (result !== 32'h0) begin errors++; $display("FAIL %s result: got %h exp 0", nm, result); end
        @(negedge clk);
        idle(); #1;
        checks++;
        if (hi !== ehi) begin errors++; $display("FAIL %s hi: got %h exp %h", nm, hi, ehi); end
        checks++;
        if (lo !== elo) begin errors++; $display("FAIL %s lo: got %h exp %h", nm, lo, elo); end
    endtask

    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input bit poke, input string nm);
        int n = 0;
        @(negedge clk);
        drive(sgn ? F_DIV : F_DIVU, a, b); reg_stall = 0; #1;
        while (alu_stall === 1'b1 && n < 40) begin
            if (poke && n == 5) begin
                hi_write = 1; hwd = 32'hCAFE; lo_write = 1; lwd = 32'hBEEF;
            end
            if (poke && n == 6) begin
                hi_write = 0; lo_write = 0;
                checks++;
                if (hi !== 32'hCAFE) begin errors++; $display("FAIL %s busy_hi_write: got %h exp cafe", nm, hi); end
            end
            n++;
            @(negedge clk); #1;
        end
        checks++;
        if (n != 33) begin errors++; $display("FAIL %s stall_cycles: got %0d exp 33", nm, n); end
        @(negedge clk);
        idle(); #1;
        checks++;
        if (hi !== ehi) begin errors++; $display("FAIL %s hi: got %h exp %h", nm, hi, ehi); end
        checks++;
        if (lo !== elo) begin errors++; $display("FAIL %s lo: got %h exp %h", nm, lo, elo); end
    endtask

    task automatic test_reset();
        #2 rst_n = 0; #1;
        checks++;
        if ({hi, lo, alu_stall, result} !== 97'h0) begin
            errors++; $display("FAIL reset_initial: got hi=%h lo=%h stall=%b res=%h exp all 0", hi, lo, alu_stall, result);
        end
        @(negedge clk); rst_n = 1;
        drive(F_MTHI, 32'h1357, 0); @(negedge clk);
        drive(F_MTLO, 32'h2468, 0); @(negedge clk);
        drive(F_DIV, 32'd100, 32'd3);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if ({hi, lo, alu_stall} !== {32'h1357, 32'h2468, 1'b1}) begin
            errors++; $display("FAIL reset_preload: got hi=%h lo=%h stall=%b exp 1357 2468 1", hi, lo, alu_stall);
        end
        rst_n = 0; #1;
        checks++;
        if ({hi, lo, alu_stall} !== 65'h0) begin
            errors++; $display("FAIL reset_mid_div: got hi=%h lo=%h stall=%b exp 0 0 0", hi, lo, alu_stall);
        end
        @(negedge clk); idle(); rst_n = 1;
        @(negedge clk); #1;
        checks++;
        if (alu_stall !== 1'b0) begin errors++; $display("FAIL reset_release_stall: got %b exp 0", alu_stall); end
        run_div(1, 32'd100, 32'd3, 32'd1, 32'd33, 0, "div_after_reset");
    endtask

    task automatic test_mult();
        logic [31:0] a, b;
        logic [63:0] p;
        bit s;
        run_mul(1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5");
        run_mul(0, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, "multu_max_x2");
        for (int i = 0; i < 20; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            p = mul_model(s, a, b);
            run_mul(s, a, b, p[63:32], p[31:0], s ? "mult_rand" : "multu_rand");
        end
    endtask

    task automatic test_div();
        logic [31:0] a, b, q, r;
        bit s;
        run_div(1, 32'd19, 32'hFFFF_FFFC, 32'd3, 32'hFFFF_FFFC, 0, "div_19_m4");
        run_div(0, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 0, "divu_max_16");
        run_div(1, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 0, "div_by_zero");
        run_div(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, "div_overflow");
        run_div(1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, "div_m7_2");
        for (int i = 0; i < 8; i++) begin
            a = $urandom; s = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            div_model(s, a, b, q, r);
            run_div(s, a, b, r, q, 0, s ? "div_rand" : "divu_rand");
        end
    endtask

    task automatic test_mt_mf();
        @(negedge clk); drive(F_MTHI, 32'h1234, 0);
        @(negedge clk); drive(F_MFHI, 0, 0); #1;
        checks++;
        if (result !== 32'h1234) begin errors++; $display("FAIL mfhi: got %h exp 1234", result); end
        @(negedge clk); drive(F_MTLO, 32'h5678, 0);
        @(negedge clk); drive(F_MFLO, 0, 0); #1;
        checks++;
        if (result !== 32'h5678) begin errors++; $display("FAIL mflo: got %h exp 5678", result); end
        @(negedge clk); drive(F_MTHI, 32'h0BAD, 0); reg_stall = 1;
        @(negedge clk); reg_stall = 0; drive(F_MFHI, 0, 0); #1;
        checks++;
        if (result !== 32'h1234) begin errors++; $display("FAIL mthi_stalled: got %h exp 1234", result); end
        @(negedge clk); oper = 4'd5; func = F_MTHI; sa = 32'hDEAD;
        @(negedge clk); idle(); #1;
        checks++;
        if (hi !== 32'h1234) begin errors++; $display("FAIL wrong_oper: got %h exp 1234", hi); end
    endtask

    task automatic test_ext_write();
        @(negedge clk); drive(F_MTHI, 32'h55, 0); hi_write = 1; hwd = 32'hAA;
        @(negedge clk); hi_write = 0; idle(); #1;
        checks++;
        if (hi !== 32'h55) begin errors++; $display("FAIL hi_write_vs_mthi: got %h exp 55", hi); end
        @(negedge clk); drive(F_MTLO, 32'h66, 0); lo_write = 1; lwd = 32'hBB;
        @(negedge clk); lo_write = 0; idle(); #1;
        checks++;
        if (lo !== 32'h66) begin errors++; $display("FAIL lo_write_vs_mtlo: got %h exp 66", lo); end
        @(negedge clk); hi_write = 1; hwd = 32'h1111; lo_write = 1; lwd = 32'h2222; reg_stall = 1;
        @(negedge clk); hi_write = 0; lo_write = 0; reg_stall = 0; #1;
        checks++;
        if ({hi, lo} !== {32'h1111, 32'h2222}) begin
            errors++; $display("FAIL ext_write_stalled: got %h %h exp 1111 2222", hi, lo);
        end
        run_div(0, 32'd1000, 32'd7, 32'd6, 32'd142, 1, "div_ext_poke");
    endtask

    task automatic test_done_stall();
        int n = 0;
        @(negedge clk); hi_write = 1; hwd = 32'hA1; lo_write = 1; lwd = 32'hB2;
        @(negedge clk); hi_write = 0; lo_write = 0;
        drive(F_DIV, 32'd100, 32'd7); reg_stall = 1; #1;
        while (alu_stall === 1'b1 && n < 40) begin
            n++;
            @(negedge clk); #1;
        end
        checks++;
        if (n != 33) begin errors++; $display("FAIL done_stall_cycles: got %0d exp 33", n); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({hi, lo, alu_stall} !== {32'hA1, 32'hB2, 1'b0}) begin
                errors++; $display("FAIL done_held_%0d: got hi=%h lo=%h stall=%b exp a1 b2 0", i, hi, lo, alu_stall);
            end
        end
        reg_stall = 0;
        @(negedge clk); idle(); #1;
        checks++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL done_commit: got %h %h exp 2 e", hi, lo); end
        hi_write = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({hi, lo, alu_stall} !== {32'd2, 32'd14, 1'b0}) begin
            errors++; $display("FAIL done_single_commit: got hi=%h lo=%h stall=%b exp 2 e 0", hi, lo, alu_stall);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt_mf();
        test_ext_write();
        test_done_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
